// File: rtl/ll_pkt_builder_if.sv
// ll_pkt_builder_if: descriptor, page allocation, link write and output queue handshakes.
interface ll_pkt_builder_if #(
  parameter int lpsz = 8,
  parameter int cntsz = 5,
  parameter int dsz = 2
);
  localparam int lpdsz = lpsz + 1;
  logic pkt_srdy;
  logic pkt_drdy;
  logic [cntsz-1:0] pkt_npages;
  logic [dsz-1:0] pkt_dest;
  logic par_srdy;
  logic par_drdy;
  logic parr_srdy;
  logic parr_drdy;
  logic [lpsz-1:0] parr_page;
  logic lnp_srdy;
  logic lnp_drdy;
  logic [lpsz+lpdsz-1:0] lnp_pnp;
  logic ip_srdy;
  logic ip_drdy;
  logic [lpsz-1:0] ip_page;
  logic [dsz-1:0] ip_dest;
  logic [cntsz-1:0] ip_npages;
  logic err_zero;
  logic [15:0] pkt_count;
  modport master (
    output pkt_srdy, pkt_npages, pkt_dest, par_drdy, parr_srdy, parr_page, lnp_drdy, ip_drdy,
    input pkt_drdy, par_srdy, parr_drdy, lnp_srdy, lnp_pnp, ip_srdy, ip_page, ip_dest, ip_npages,
    input err_zero, pkt_count
  );
  modport slave (
    input pkt_srdy, pkt_npages, pkt_dest, par_drdy, parr_srdy, parr_page, lnp_drdy, ip_drdy,
    output pkt_drdy, par_srdy, parr_drdy, lnp_srdy, lnp_pnp, ip_srdy, ip_page, ip_dest, ip_npages,
    output err_zero, pkt_count
  );
endinterface

// File: rtl/ll_pkt_builder.sv
// ll_pkt_builder: allocates npages pages per descriptor, links them into a stop-terminated chain
// and enqueues the head page with its destination to the output queue.
module ll_pkt_builder #(
  parameter int lpsz = 8,
  parameter int cntsz = 5,
  parameter int dsz = 2
) (
  input logic clk,
  input logic reset,
  ll_pkt_builder_if.slave b
);
  localparam int lpdsz = lpsz + 1;
  typedef enum logic [2:0] {IDLE, REQ, RESP, LINK, LSTOP, SEND} state_t;
  state_t state, n_state;
  logic [cntsz-1:0] np, n_np, rem, n_rem;
  logic [dsz-1:0] dest, n_dest;
  logic [lpsz-1:0] cur, n_cur, prev, n_prev, head, n_head;
  logic first, n_first;
  logic [15:0] count;
  logic pkt_x, par_x, parr_x, lnp_x, ip_x;
  logic o_pkt_drdy, o_par_srdy, o_parr_drdy, o_lnp_srdy, o_ip_srdy, o_err;
  logic [lpsz+lpdsz-1:0] o_lnp_pnp;
  logic [lpsz-1:0] o_ip_page;
  logic [dsz-1:0] o_ip_dest;
  logic [cntsz-1:0] o_ip_npages;
  assign pkt_x = b.pkt_srdy & b.pkt_drdy;
  assign par_x = b.par_srdy & b.par_drdy;
  assign parr_x = b.parr_srdy & b.parr_drdy;
  assign lnp_x = b.lnp_srdy & b.lnp_drdy;
  assign ip_x = b.ip_srdy & b.ip_drdy;
  assign b.pkt_count = count;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      np <= '0;
      rem <= '0;
      dest <= '0;
      cur <= '0;
      prev <= '0;
      head <= '0;
      first <= 1'b0;
      count <= '0;
      b.pkt_drdy <= 1'b0;
      b.par_srdy <= 1'b0;
      b.parr_drdy <= 1'b0;
      b.lnp_srdy <= 1'b0;
      b.lnp_pnp <= '0;
      b.ip_srdy <= 1'b0;
      b.ip_page <= '0;
      b.ip_dest <= '0;
      b.ip_npages <= '0;
      b.err_zero <= 1'b0;
    end else begin
      state <= n_state;
      np <= n_np;
      rem <= n_rem;
      dest <= n_dest;
      cur <= n_cur;
      prev <= n_prev;
      head <= n_head;
      first <= n_first;
      count <= count + {15'd0, ip_x};
      b.pkt_drdy <= o_pkt_drdy;
      b.par_srdy <= o_par_srdy;
      b.parr_drdy <= o_parr_drdy;
      b.lnp_srdy <= o_lnp_srdy;
      b.lnp_pnp <= o_lnp_pnp;
      b.ip_srdy <= o_ip_srdy;
      b.ip_page <= o_ip_page;
      b.ip_dest <= o_ip_dest;
      b.ip_npages <= o_ip_npages;
      b.err_zero <= o_err;
    end
  end
  always_comb begin
    n_state = state;
    n_np = np;
    n_rem = rem;
    n_dest = dest;
    n_cur = cur;
    n_prev = prev;
    n_head = head;
    n_first = first;
    case (state)
      IDLE: if (pkt_x && b.pkt_npages != '0) begin
        n_np = b.pkt_npages;
        n_dest = b.pkt_dest;
        n_rem = b.pkt_npages;
        n_first = 1'b1;
        n_state = REQ;
      end
      REQ: if (par_x) n_state = RESP;
      RESP: if (parr_x) begin
        n_cur = b.parr_page;
        n_rem = rem - cntsz'(1);
        if (first) begin
          n_head = b.parr_page;
          n_prev = b.parr_page;
          n_first = 1'b0;
          n_state = rem == cntsz'(1) ? LSTOP : REQ;
        end else n_state = LINK;
      end
      LINK: if (lnp_x) begin
        n_prev = cur;
        n_state = rem == '0 ? LSTOP : REQ;
      end
      LSTOP: if (lnp_x) n_state = SEND;
      SEND: if (ip_x) n_state = IDLE;
      default: n_state = IDLE;
    endcase
  end
  // Outputs are computed from next-cycle state/data so every port comes straight from a flop.
  always_comb begin
    o_pkt_drdy = n_state == IDLE;
    o_par_srdy = n_state == REQ;
    o_parr_drdy = n_state == RESP;
    o_lnp_srdy = n_state == LINK || n_state == LSTOP;
    o_lnp_pnp = n_state == LINK ? {n_prev, 1'b0, n_cur} :
                n_state == LSTOP ? {n_prev, 1'b1, {lpsz{1'b0}}} : '0;
    o_ip_srdy = n_state == SEND;
    o_ip_page = o_ip_srdy ? n_head : '0;
    o_ip_dest = o_ip_srdy ? n_dest : '0;
    o_ip_npages = o_ip_srdy ? n_np : '0;
    o_err = pkt_x && b.pkt_npages == '0;
  end
endmodule

// File: tb/tb_ll_pkt_builder.sv
// tb_ll_pkt_builder: directed checks of chain building, rejection, stalls, reset abort and counter wrap.
module tb_ll_pkt_builder;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int total = 0, bad = 0, cyc = 0, npar = 0, unstable = 0, tmo = 0;
  bit stall = 0, lnp_hold = 0, parr_x = 0;
  logic [7:0] pgs[$], pend[$];
  logic [16:0] lnp_q[$];
  logic [14:0] ip_q[$];
  int acc_q[$], err_q[$];
  ll_pkt_builder_if bus();
  ll_pkt_builder dut (.clk(clk), .reset(reset), .b(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    bus.par_drdy = 1'b0;
    bus.lnp_drdy = 1'b0;
    bus.ip_drdy = 1'b0;
    bus.parr_srdy = 1'b0;
    bus.parr_page = 8'h00;
    forever begin
      @(posedge clk);
      #1;
      bus.par_drdy = !stall || $urandom_range(0, 2) == 0;
      bus.lnp_drdy = !lnp_hold && (!stall || $urandom_range(0, 2) == 0);
      bus.ip_drdy = !stall || $urandom_range(0, 2) == 0;
      if (!bus.parr_srdy || parr_x) begin
        bus.parr_srdy = pend.size() > 0 && (!stall || $urandom_range(0, 2) == 0);
        bus.parr_page = bus.parr_srdy ? pend[0] : 8'h00;
      end
    end
  end
  initial begin
    logic w_lnp, w_par, w_ip;
    logic [16:0] h_lnp;
    logic [14:0] h_ip;
    w_lnp = 0;
    w_par = 0;
    w_ip = 0;
    h_lnp = '0;
    h_ip = '0;
    forever begin
      @(negedge clk);
      parr_x = bus.parr_srdy && bus.parr_drdy;
      if (parr_x) void'(pend.pop_front());
      if (bus.par_srdy && bus.par_drdy) begin
        npar++;
        pend.push_back(pgs.size() > 0 ? pgs.pop_front() : 8'hEE);
      end
      if (bus.pkt_srdy && bus.pkt_drdy) acc_q.push_back(cyc);
      if (bus.err_zero) err_q.push_back(cyc);
      if (bus.lnp_srdy && bus.lnp_drdy) lnp_q.push_back(bus.lnp_pnp);
      if (bus.ip_srdy && bus.ip_drdy) ip_q.push_back({bus.ip_page, bus.ip_dest, bus.ip_npages});
      if ((w_lnp && (!bus.lnp_srdy || bus.lnp_pnp !== h_lnp)) || (w_par && !bus.par_srdy) ||
          (w_ip && (!bus.ip_srdy || {bus.ip_page, bus.ip_dest, bus.ip_npages} !== h_ip)))
        unstable++;
      w_lnp = bus.lnp_srdy && !bus.lnp_drdy;
      w_par = bus.par_srdy && !bus.par_drdy;
      w_ip = bus.ip_srdy && !bus.ip_drdy;
      h_lnp = bus.lnp_pnp;
      h_ip = {bus.ip_page, bus.ip_dest, bus.ip_npages};
    end
  end
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic put_desc(input logic [4:0] n, input logic [1:0] d);
    int i = 0;
    bus.pkt_srdy = 1'b1;
    bus.pkt_npages = n;
    bus.pkt_dest = d;
    while (!bus.pkt_drdy && i < 4000) begin
      tick();
      i++;
    end
    if (!bus.pkt_drdy) tmo++;
    tick();
    bus.pkt_srdy = 1'b0;
  endtask
  task automatic wait_ip(input int k);
    int i = 0;
    while (ip_q.size() < k && i < 4000) begin
      tick();
      i++;
    end
    if (ip_q.size() < k) tmo++;
  endtask
  task automatic clear_q;
    lnp_q.delete();
    ip_q.delete();
    acc_q.delete();
    err_q.delete();
    tmo = 0;
  endtask
  task automatic test_reset;
    reset = 1'b1;
    tick(3);
    total++;
    if ({bus.pkt_drdy, bus.par_srdy, bus.parr_drdy, bus.lnp_srdy, bus.ip_srdy, bus.err_zero} !== 6'b0) begin
      bad++;
      $display("FAIL reset_hs: got %b want 000000",
               {bus.pkt_drdy, bus.par_srdy, bus.parr_drdy, bus.lnp_srdy, bus.ip_srdy, bus.err_zero});
    end
    total++;
    if ({bus.lnp_pnp, bus.ip_page, bus.ip_dest, bus.ip_npages} !== 32'h0) begin
      bad++;
      $display("FAIL reset_data: got %h want 0", {bus.lnp_pnp, bus.ip_page, bus.ip_dest, bus.ip_npages});
    end
    total++;
    if (bus.pkt_count !== 16'h0) begin
      bad++;
      $display("FAIL reset_count: got %h want 0000", bus.pkt_count);
    end
    reset = 1'b0;
    tick();
    total++;
    if (bus.pkt_drdy !== 1'b1 || bus.par_srdy !== 1'b0) begin
      bad++;
      $display("FAIL reset_release: pkt_drdy=%b par_srdy=%b want 1 0", bus.pkt_drdy, bus.par_srdy);
    end
  endtask
  task automatic test_single;
    clear_q();
    pgs = '{8'd5};
    put_desc(5'd1, 2'd2);
    wait_ip(1);
    total++;
    if (lnp_q.size() !== 1 || lnp_q[0] !== {8'd5, 1'b1, 8'd0}) begin
      bad++;
      $display("FAIL single_lnp: size=%0d got %h want %h", lnp_q.size(), lnp_q[0], {8'd5, 1'b1, 8'd0});
    end
    total++;
    if (ip_q[0] !== {8'd5, 2'd2, 5'd1}) begin
      bad++;
      $display("FAIL single_ip: got %h want %h", ip_q[0], {8'd5, 2'd2, 5'd1});
    end
    total++;
    if (bus.pkt_count !== 16'd1 || tmo !== 0) begin
      bad++;
      $display("FAIL single_count: got %0d tmo=%0d want 1 tmo=0", bus.pkt_count, tmo);
    end
  endtask
  task automatic test_back_to_back;
    logic [16:0] el[$];
    clear_q();
    pgs = '{8'd7, 8'd3, 8'd9, 8'd4, 8'd8};
    el = '{{8'd7, 1'b0, 8'd3}, {8'd3, 1'b0, 8'd9}, {8'd9, 1'b1, 8'd0}, {8'd4, 1'b1, 8'd0}, {8'd8, 1'b1, 8'd0}};
    put_desc(5'd3, 2'd1);
    put_desc(5'd1, 2'd3);
    put_desc(5'd1, 2'd0);
    wait_ip(3);
    total++;
    if (lnp_q.size() !== 5) begin
      bad++;
      $display("FAIL b2b_lnp_len: got %0d want 5", lnp_q.size());
    end
    for (int i = 0; i < 5 && i < lnp_q.size(); i++) begin
      total++;
      if (lnp_q[i] !== el[i]) begin
        bad++;
        $display("FAIL b2b_lnp[%0d]: got %h want %h", i, lnp_q[i], el[i]);
      end
    end
    total++;
    if (ip_q[0] !== {8'd7, 2'd1, 5'd3} || ip_q[1] !== {8'd4, 2'd3, 5'd1} || ip_q[2] !== {8'd8, 2'd0, 5'd1}) begin
      bad++;
      $display("FAIL b2b_ip: got %h %h %h want %h %h %h", ip_q[0], ip_q[1], ip_q[2],
               {8'd7, 2'd1, 5'd3}, {8'd4, 2'd3, 5'd1}, {8'd8, 2'd0, 5'd1});
    end
    total++;
    if (acc_q[1] - acc_q[0] !== 11) begin
      bad++;
      $display("FAIL b2b_interval3: got %0d want 11", acc_q[1] - acc_q[0]);
    end
    total++;
    if (acc_q[2] - acc_q[1] !== 5) begin
      bad++;
      $display("FAIL b2b_interval1: got %0d want 5", acc_q[2] - acc_q[1]);
    end
    total++;
    if (bus.pkt_count !== 16'd4 || tmo !== 0) begin
      bad++;
      $display("FAIL b2b_count: got %0d tmo=%0d want 4 tmo=0", bus.pkt_count, tmo);
    end
  endtask
  task automatic test_zero;
    int np0;
    logic [15:0] c0;
    clear_q();
    np0 = npar;
    c0 = bus.pkt_count;
    put_desc(5'd0, 2'd1);
    put_desc(5'd0, 2'd2);
    tick(3);
    total++;
    if (err_q.size() !== 2 || acc_q.size() !== 2) begin
      bad++;
      $display("FAIL zero_pulses: err=%0d acc=%0d want 2 2", err_q.size(), acc_q.size());
    end
    total++;
    if (err_q[0] !== acc_q[0] + 1 || err_q[1] !== err_q[0] + 1 || acc_q[1] !== acc_q[0] + 1) begin
      bad++;
      $display("FAIL zero_timing: acc %0d %0d err %0d %0d want err=acc+1 consecutive",
               acc_q[0], acc_q[1], err_q[0], err_q[1]);
    end
    total++;
    if (npar !== np0 || bus.pkt_count !== c0) begin
      bad++;
      $display("FAIL zero_side: par=%0d count=%0d want %0d %0d", npar, bus.pkt_count, np0, c0);
    end
    pgs = '{8'd11, 8'd12};
    put_desc(5'd2, 2'd3);
    wait_ip(1);
    total++;
    if (lnp_q.size() !== 2 || lnp_q[0] !== {8'd11, 1'b0, 8'd12} || lnp_q[1] !== {8'd12, 1'b1, 8'd0}) begin
      bad++;
      $display("FAIL zero_next_lnp: size=%0d got %h %h", lnp_q.size(), lnp_q[0], lnp_q[1]);
    end
    total++;
    if (ip_q[0] !== {8'd11, 2'd3, 5'd2} || err_q.size() !== 2 || tmo !== 0) begin
      bad++;
      $display("FAIL zero_next_ip: got %h err=%0d tmo=%0d want %h 2 0", ip_q[0], err_q.size(), tmo,
               {8'd11, 2'd3, 5'd2});
    end
  endtask
  task automatic test_stalls;
    logic [16:0] el[$];
    logic [14:0] ei[$];
    logic [7:0] p[$];
    logic [7:0] pg;
    int n;
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    tick();
    clear_q();
    pg = 8'h10;
    stall = 1;
    unstable = 0;
    for (int i = 0; i < 20; i++) begin
      n = i == 0 ? 31 : (i * 7) % 31 + 1;
      p.delete();
      for (int j = 0; j < n; j++) begin
        p.push_back(pg);
        pgs.push_back(pg);
        pg++;
      end
      for (int j = 0; j < n - 1; j++) el.push_back({p[j], 1'b0, p[j+1]});
      el.push_back({p[n-1], 1'b1, 8'd0});
      ei.push_back({p[0], 2'(i % 4), 5'(n)});
      put_desc(5'(n), 2'(i % 4));
      wait_ip(i + 1);
    end
    stall = 0;
    tick(2);
    total++;
    if (lnp_q.size() !== el.size() || ip_q.size() !== 20) begin
      bad++;
      $display("FAIL stall_len: lnp=%0d ip=%0d want %0d 20", lnp_q.size(), ip_q.size(), el.size());
    end
    for (int i = 0; i < el.size() && i < lnp_q.size(); i++) begin
      total++;
      if (lnp_q[i] !== el[i]) begin
        bad++;
        $display("FAIL stall_lnp[%0d]: got %h want %h", i, lnp_q[i], el[i]);
      end
    end
    for (int i = 0; i < 20 && i < ip_q.size(); i++) begin
      total++;
      if (ip_q[i] !== ei[i]) begin
        bad++;
        $display("FAIL stall_ip[%0d]: got %h want %h", i, ip_q[i], ei[i]);
      end
    end
    total++;
    if (unstable !== 0 || tmo !== 0) begin
      bad++;
      $display("FAIL stall_stable: unstable=%0d tmo=%0d want 0 0", unstable, tmo);
    end
    total++;
    if (bus.pkt_count !== 16'd20) begin
      bad++;
      $display("FAIL stall_count: got %0d want 20", bus.pkt_count);
    end
  endtask
  task automatic test_reset_mid;
    int i = 0;
    clear_q();
    pgs = '{8'd20, 8'd21, 8'd22, 8'd23};
    lnp_hold = 1;
    put_desc(5'd4, 2'd0);
    while (!bus.lnp_srdy && i < 100) begin
      tick();
      i++;
    end
    total++;
    if (bus.lnp_srdy !== 1'b1 || bus.lnp_pnp !== {8'd20, 1'b0, 8'd21}) begin
      bad++;
      $display("FAIL mid_link: srdy=%b pnp=%h want 1 %h", bus.lnp_srdy, bus.lnp_pnp, {8'd20, 1'b0, 8'd21});
    end
    reset = 1'b1;
    tick();
    total++;
    if ({bus.pkt_drdy, bus.par_srdy, bus.parr_drdy, bus.lnp_srdy, bus.ip_srdy, bus.err_zero} !== 6'b0 ||
        {bus.lnp_pnp, bus.ip_page, bus.ip_dest, bus.ip_npages, bus.pkt_count} !== 48'h0) begin
      bad++;
      $display("FAIL mid_reset: hs=%b data=%h want 0",
               {bus.pkt_drdy, bus.par_srdy, bus.parr_drdy, bus.lnp_srdy, bus.ip_srdy, bus.err_zero},
               {bus.lnp_pnp, bus.ip_page, bus.ip_dest, bus.ip_npages, bus.pkt_count});
    end
    tick();
    reset = 1'b0;
    lnp_hold = 0;
    pgs.delete();
    tick(12);
    total++;
    if (lnp_q.size() !== 0 || ip_q.size() !== 0 || bus.pkt_drdy !== 1'b1 || bus.par_srdy !== 1'b0) begin
      bad++;
      $display("FAIL mid_after: lnp=%0d ip=%0d drdy=%b par=%b want 0 0 1 0", lnp_q.size(), ip_q.size(),
               bus.pkt_drdy, bus.par_srdy);
    end
  endtask
  task automatic test_wrap;
    clear_q();
    force dut.count = 16'hFFFF;
    tick();
    release dut.count;
    tick();
    total++;
    if (bus.pkt_count !== 16'hFFFF) begin
      bad++;
      $display("FAIL wrap_preload: got %h want ffff", bus.pkt_count);
    end
    pgs = '{8'd30};
    put_desc(5'd1, 2'd1);
    wait_ip(1);
    total++;
    if (bus.pkt_count !== 16'h0000 || ip_q[0] !== {8'd30, 2'd1, 5'd1} || tmo !== 0) begin
      bad++;
      $display("FAIL wrap_count: got %h ip=%h tmo=%0d want 0000 %h 0", bus.pkt_count, ip_q[0], tmo,
               {8'd30, 2'd1, 5'd1});
    end
  endtask
  initial begin
    bus.pkt_srdy = 1'b0;
    bus.pkt_npages = '0;
    bus.pkt_dest = '0;
    test_reset();
    test_single();
    test_back_to_back();
    test_zero();
    test_stalls();
    test_reset_mid();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
